// File: rtl/clk_monitor.sv
// Receive-side clock checker: measures high/low/period of an asynchronous clk_in
// in system-clock cycles, flags out-of-tolerance phases and loss of clock.
module clk_monitor #(
  parameter int CNT_W    = 16,
  parameter int EXP_HIGH = 4,
  parameter int EXP_LOW  = 4,
  parameter int TOL      = 1,
  parameter int TIMEOUT  = 1024,
  parameter int EDGE_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_in,
  input  logic              enable,
  input  logic              clear,
  output logic [CNT_W-1:0]  high_len,
  output logic [CNT_W-1:0]  low_len,
  output logic [CNT_W:0]    period,
  output logic              meas_valid,
  output logic              period_err,
  output logic              clk_lost,
  output logic [EDGE_W-1:0] edge_count
);

  localparam logic [CNT_W-1:0] EXP_H   = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] EXP_L   = CNT_W'(EXP_LOW);
  localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ALIGN, MEAS_HIGH, MEAS_LOW} state_t;

  state_t           state, state_nxt;
  logic [2:0]       sync_pipe;  // [0],[1] synchronizer, [2] edge-detect delay
  logic             rise, fall;
  logic [CNT_W-1:0] cnt;
  logic             act, timeout;
  logic             latch_high, latch_low, load_cnt, set_lost, count_edge;

  function automatic logic [CNT_W-1:0] absdiff(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[1:0], clk_in};
  end

  assign rise    = sync_pipe[1] & ~sync_pipe[2];
  assign fall    = ~sync_pipe[1] & sync_pipe[2];
  assign act     = enable & ~clear;
  assign timeout = (cnt == TO_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Disable beats clear, clear beats any edge or timeout
  always_comb begin
    state_nxt = state;
    if (!enable)     state_nxt = IDLE;
    else if (clear)  state_nxt = ALIGN;
    else begin
      case (state)
        IDLE:      state_nxt = ALIGN;
        ALIGN:     if (rise) state_nxt = MEAS_HIGH;
        MEAS_HIGH: if (fall) state_nxt = MEAS_LOW;
                   else if (timeout) state_nxt = ALIGN;
        MEAS_LOW:  if (rise) state_nxt = MEAS_HIGH;
                   else if (timeout) state_nxt = ALIGN;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    latch_high = act & (state == MEAS_HIGH) & fall;
    latch_low  = act & (state == MEAS_LOW) & rise;
    load_cnt   = latch_high | latch_low | (act & (state == ALIGN) & rise);
    set_lost   = act & timeout &
                 (((state == MEAS_HIGH) & ~fall) | ((state == MEAS_LOW) & ~rise));
    count_edge = act & (state != IDLE) & rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load_cnt) begin
      cnt <= CNT_W'(1);
    end else if ((state == MEAS_HIGH || state == MEAS_LOW) && cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_len   <= '0;
      low_len    <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= latch_low;
      if (latch_high) high_len <= cnt;
      if (latch_low) begin
        low_len <= cnt;
        period  <= {1'b0, high_len} + {1'b0, cnt};
      end
    end
  end

  // Status flags: clear zeroes them regardless of enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_err <= 1'b0;
      clk_lost   <= 1'b0;
      edge_count <= '0;
    end else if (clear) begin
      period_err <= 1'b0;
      clk_lost   <= 1'b0;
      edge_count <= '0;
    end else begin
      if (latch_low && (absdiff(high_len, EXP_H) > TOL_C || absdiff(cnt, EXP_L) > TOL_C))
        period_err <= 1'b1;
      if (latch_low)     clk_lost <= 1'b0;
      else if (set_lost) clk_lost <= 1'b1;
      if (count_edge) edge_count <= edge_count + EDGE_W'(1);
    end
  end

endmodule

// File: tb/tb_clk_monitor.sv
// Directed + randomized bench for clk_monitor against a timestamp-based reference model.
module tb_clk_monitor;
  localparam int CNT_W = 16, EXP_HIGH = 4, EXP_LOW = 4, TOL = 1, TIMEOUT = 1024, EDGE_W = 32;

  logic              clk = 1'b0;
  logic              rst_n, clk_in, enable, clear;
  logic [CNT_W-1:0]  high_len, low_len;
  logic [CNT_W:0]    period;
  logic              meas_valid, period_err, clk_lost;
  logic [EDGE_W-1:0] edge_count;

  int tests = 0;
  int fails = 0;

  clk_monitor #(.CNT_W(CNT_W), .EXP_HIGH(EXP_HIGH), .EXP_LOW(EXP_LOW), .TOL(TOL),
                .TIMEOUT(TIMEOUT), .EDGE_W(EDGE_W)) dut (
    .clk(clk), .rst_n(rst_n), .clk_in(clk_in), .enable(enable), .clear(clear),
    .high_len(high_len), .low_len(low_len), .period(period), .meas_valid(meas_valid),
    .period_err(period_err), .clk_lost(clk_lost), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  // Reference model: phase lengths are differences of edge timestamps
  bit [3:0]    hist;
  int          m_cyc, m_t, m_h, m_l, m_p;
  bit          m_mv, m_err, m_lost, m_idle, m_aligned, m_inhigh;
  int unsigned m_ec;

  function automatic int dev(input int x, input int e);
    return (x > e) ? x - e : e - x;
  endfunction

  function automatic void m_reset();
    hist = '0; m_cyc = 0; m_t = 0; m_h = 0; m_l = 0; m_p = 0;
    m_mv = 0; m_err = 0; m_lost = 0; m_ec = 0;
    m_idle = 1; m_aligned = 0; m_inhigh = 0;
  endfunction

  function automatic void m_step(input bit ci, input bit en, input bit clr);
    bit r, f;
    int len;
    hist = {hist[2:0], ci};
    r = hist[2] & ~hist[3];
    f = ~hist[2] & hist[3];
    m_cyc++;
    m_mv = 0;
    if (clr) begin m_err = 0; m_lost = 0; m_ec = 0; end
    if (!en) m_idle = 1;
    else if (clr || m_idle) begin m_idle = 0; m_aligned = 0; end
    else begin
      if (r) m_ec++;
      len = m_cyc - m_t;
      if (!m_aligned) begin
        if (r) begin m_aligned = 1; m_inhigh = 1; m_t = m_cyc; end
      end else if (m_inhigh ? f : r) begin
        if (m_inhigh) m_h = len;
        else begin
          m_l = len; m_p = m_h + len; m_mv = 1; m_lost = 0;
          if (dev(m_h, EXP_HIGH) > TOL || dev(len, EXP_LOW) > TOL) m_err = 1;
        end
        m_inhigh = !m_inhigh;
        m_t = m_cyc;
      end else if (len == TIMEOUT) begin
        m_lost = 1; m_aligned = 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".high_len"},   64'(high_len),   64'(m_h));
    chk({tag, ".low_len"},    64'(low_len),    64'(m_l));
    chk({tag, ".period"},     64'(period),     64'(m_p));
    chk({tag, ".meas_valid"}, 64'(meas_valid), 64'(m_mv));
    chk({tag, ".period_err"}, 64'(period_err), 64'(m_err));
    chk({tag, ".clk_lost"},   64'(clk_lost),   64'(m_lost));
    chk({tag, ".edge_count"}, 64'(edge_count), 64'(m_ec));
  endtask

  // Called at a negedge: drive, advance the model, sample at the next negedge
  task automatic step(input bit ci, input bit en, input bit clr);
    clk_in = ci; enable = en; clear = clr;
    m_step(ci, en, clr);
    @(negedge clk);
    check_all("cyc");
  endtask

  task automatic periods(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < l; i++) step(1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    bit          en_r;
    int unsigned ec_saved;
    rst_n = 1'b0; clk_in = 1'b0; enable = 1'b0; clear = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // nominal 4/4
    repeat (3) step(1'b0, 1'b1, 1'b0);
    periods(4, 4, 5);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    chk("nom_ec", 64'(edge_count), 64'd5);
    chk("nom_high", 64'(high_len), 64'd4);
    chk("nom_low", 64'(low_len), 64'd4);
    chk("nom_period", 64'(period), 64'd8);
    chk("nom_err", 64'(period_err), 64'd0);

    // asymmetric 4/7, then nominal: error stays sticky
    periods(4, 7, 3);
    chk("asym_low", 64'(low_len), 64'd7);
    chk("asym_period", 64'(period), 64'd11);
    chk("asym_err", 64'(period_err), 64'd1);
    periods(4, 4, 3);
    chk("sticky_err", 64'(period_err), 64'd1);

    // clear on the cycle an out-of-tolerance measurement would latch
    periods(4, 7, 1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_mv", 64'(meas_valid), 64'd0);
    chk("clr_err", 64'(period_err), 64'd0);
    chk("clr_ec", 64'(edge_count), 64'd0);
    step(1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0);

    // loss of clock, then restart
    periods(4, 4, 2);
    repeat (TIMEOUT + 20) step(1'b1, 1'b1, 1'b0);
    chk("loss_flag", 64'(clk_lost), 64'd1);
    periods(4, 4, 3);
    chk("loss_clear", 64'(clk_lost), 64'd0);
    chk("loss_high", 64'(high_len), 64'd4);

    // async reset during the low phase
    periods(4, 4, 2);
    repeat (4) step(1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    m_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b1, 1'b0);
    periods(4, 4, 3);

    // disable mid-high while clk_in keeps toggling
    periods(4, 4, 1);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    ec_saved = m_ec;
    for (int i = 0; i < 20; i++) step(((i / 3) % 2) == 0, 1'b0, 1'b0);
    chk("dis_ec", 64'(edge_count), 64'(ec_saved));
    periods(4, 4, 3);

    // randomized phases, clears and enable drops
    en_r = 1'b1;
    for (int p = 0; p < 60; p++) begin
      int hl, ll;
      hl = $urandom_range(1, 9);
      ll = $urandom_range(1, 9);
      for (int i = 0; i < hl + ll; i++) begin
        if (en_r ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 5) == 0)) en_r = ~en_r;
        step(i < hl, en_r, $urandom_range(0, 49) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
